// File: rtl/pwm_pkg.sv
// Shared widths and ramp FSM state encoding for the pwm block family.
package pwm_pkg;

    localparam int DUTY_W = 20;
    localparam int GAP_W  = 12;

    typedef enum logic {
        IDLE = 1'b0,
        RAMP = 1'b1
    } ramp_state_e;

endpackage

// File: rtl/pwm_duty_ramp_if.sv
// Command handshake carrying a duty target, slew step and gap value.
interface pwm_duty_ramp_if;
    import pwm_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_target;
    logic [DUTY_W-1:0] cmd_step;
    logic [GAP_W-1:0]  cmd_gap;

    modport master (
        output cmd_valid,
        output cmd_target,
        output cmd_step,
        output cmd_gap,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_target,
        input  cmd_step,
        input  cmd_gap,
        output cmd_ready
    );

endinterface

// File: rtl/pwm_tick_div.sv
// Modulo-TICK_DIV counter; tick is high on the enabled last count.
module pwm_tick_div #(
    parameter int TICK_DIV = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        tick  = en && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr || tick) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/pwm_duty_ramp.sv
// Slews duty_need toward a commanded target one step per TICK_DIV clocks,
// latching duty_gap per command for the downstream pwm stage.
module pwm_duty_ramp
    import pwm_pkg::*;
#(
    parameter int                TICK_DIV = 1000,
    parameter logic [DUTY_W-1:0] DUTY_MAX = 20'hFFFFF,
    parameter logic [GAP_W-1:0]  GAP_RST  = 12'd10
) (
    input  logic              clk,
    input  logic              rst,
    pwm_duty_ramp_if.slave    cmd,
    input  logic              hold,
    output logic [DUTY_W-1:0] duty_need,
    output logic [GAP_W-1:0]  duty_gap,
    output logic              busy,
    output logic              done
);

    ramp_state_e       state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic [DUTY_W-1:0] step_q, step_d;
    logic [GAP_W-1:0]  gap_q, gap_d;
    logic              done_q, done_d;

    logic              accept;
    logic              tick;
    logic [DUTY_W-1:0] tgt_in;
    logic [DUTY_W-1:0] diff;
    logic [DUTY_W-1:0] duty_nxt;

    assign cmd.cmd_ready = (state_q == IDLE) && !rst;
    assign accept = cmd.cmd_valid && cmd.cmd_ready;
    assign tgt_in = (cmd.cmd_target > DUTY_MAX) ? DUTY_MAX : cmd.cmd_target;

    pwm_tick_div #(
        .TICK_DIV (TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .en   ((state_q == RAMP) && !hold),
        .clr  (accept),
        .tick (tick)
    );

    // Step by comparing the remaining distance, so the sum never wraps.
    always_comb begin
        if (duty_q < tgt_q) begin
            diff     = tgt_q - duty_q;
            duty_nxt = (diff <= step_q) ? tgt_q : duty_q + step_q;
        end else begin
            diff     = duty_q - tgt_q;
            duty_nxt = (diff <= step_q) ? tgt_q : duty_q - step_q;
        end
    end

    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        tgt_d   = tgt_q;
        step_d  = step_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    tgt_d  = tgt_in;
                    step_d = cmd.cmd_step;
                    gap_d  = cmd.cmd_gap;
                    if (cmd.cmd_step == '0 || tgt_in == duty_q) begin
                        duty_d = tgt_in;
                        done_d = 1'b1;
                    end else begin
                        state_d = RAMP;
                    end
                end
            end
            RAMP: begin
                if (tick) begin
                    duty_d = duty_nxt;
                    if (duty_nxt == tgt_q) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            duty_q  <= '0;
            tgt_q   <= '0;
            step_q  <= '0;
            gap_q   <= GAP_RST;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            duty_q  <= duty_d;
            tgt_q   <= tgt_d;
            step_q  <= step_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    assign duty_need = duty_q;
    assign duty_gap  = gap_q;
    assign busy      = (state_q == RAMP);
    assign done      = done_q;

endmodule

// File: tb/tb_pwm_duty_ramp.sv
// Directed and randomized checks of pwm_duty_ramp against a cycle model.
module tb_pwm_duty_ramp;
    import pwm_pkg::*;

    localparam int TD   = 4;
    localparam int DMAX = 1000;

    logic              clk;
    logic              rst;
    logic              hold;
    logic [DUTY_W-1:0] duty_need;
    logic [GAP_W-1:0]  duty_gap;
    logic              busy;
    logic              done;

    pwm_duty_ramp_if cmd_if ();

    pwm_duty_ramp #(
        .TICK_DIV (TD),
        .DUTY_MAX (20'(DMAX)),
        .GAP_RST  (12'd10)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd       (cmd_if),
        .hold      (hold),
        .duty_need (duty_need),
        .duty_gap  (duty_gap),
        .busy      (busy),
        .done      (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total  = 0;
    int passed = 0;

    task automatic chk(string name, longint act, longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a step lands after every TD un-held ramp clocks.
    longint m_duty = 0, m_tgt = 0, m_step = 0, m_gap = 10;
    bit     m_busy = 0, m_done = 0;
    int     m_left = 0;

    always @(posedge clk) begin
        longint t, d;
        if (rst) begin
            m_duty = 0; m_gap = 10; m_busy = 0; m_done = 0; m_left = 0;
        end else begin
            m_done = 0;
            if (!m_busy) begin
                if (cmd_if.cmd_valid) begin
                    t = cmd_if.cmd_target;
                    if (t > DMAX) t = DMAX;
                    m_gap = cmd_if.cmd_gap;
                    if (cmd_if.cmd_step == 0 || t == m_duty) begin
                        m_duty = t;
                        m_done = 1;
                    end else begin
                        m_tgt  = t;
                        m_step = cmd_if.cmd_step;
                        m_busy = 1;
                        m_left = TD;
                    end
                end
            end else if (!hold) begin
                m_left--;
                if (m_left == 0) begin
                    d = m_tgt - m_duty;
                    if (d > 0) m_duty += (d < m_step) ? d : m_step;
                    else m_duty -= (-d < m_step) ? -d : m_step;
                    m_left = TD;
                    if (m_duty == m_tgt) begin
                        m_busy = 0;
                        m_done = 1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        chk("duty_need", duty_need, m_duty);
        chk("duty_gap", duty_gap, m_gap);
        chk("busy", busy, m_busy);
        chk("done", done, m_done);
        chk("cmd_ready", cmd_if.cmd_ready, (!m_busy && !rst) ? 1 : 0);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(int tgt, int step, int gap);
        cmd_if.cmd_valid  = 1'b1;
        cmd_if.cmd_target = 20'(tgt);
        cmd_if.cmd_step   = 20'(step);
        cmd_if.cmd_gap    = 12'(gap);
        tick();
        cmd_if.cmd_valid  = 1'b0;
    endtask

    task automatic wait_done(string name);
        int n = 0;
        while (!done && n < 400) begin
            tick();
            n++;
        end
        chk(name, done, 1);
    endtask

    initial begin
        rst = 1'b1;
        hold = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        cmd_if.cmd_target = '0;
        cmd_if.cmd_step = '0;
        cmd_if.cmd_gap = '0;
        tick();
        tick();
        chk("rst_duty", duty_need, 0);
        chk("rst_gap", duty_gap, 10);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cmd_if.cmd_ready, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", cmd_if.cmd_ready, 1);

        send(20, 5, 10);
        chk("up_gap", duty_gap, 10);
        chk("up_busy", busy, 1);
        chk("up_model", m_duty, 0);
        for (int k = 1; k <= 4; k++) begin
            repeat (TD) tick();
            chk("up_step", duty_need, 5 * k);
        end
        chk("up_done", done, 1);
        chk("up_busy_fall", busy, 0);

        send(3, 8, 10);
        repeat (TD) tick();
        chk("dn_12", duty_need, 12);
        repeat (TD) tick();
        chk("dn_4", duty_need, 4);
        chk("dn_nodone", done, 0);
        repeat (TD) tick();
        chk("dn_3", duty_need, 3);
        chk("dn_done", done, 1);

        send(500, 0, 7);
        chk("jump_duty", duty_need, 500);
        chk("jump_done", done, 1);
        chk("jump_busy", busy, 0);
        chk("jump_gap", duty_gap, 7);
        tick();
        send(500, 0, 7);
        chk("noop_done", done, 1);
        chk("noop_duty", duty_need, 500);

        send(600, 25, 3);
        repeat (5) tick();
        chk("hold_pre", duty_need, 525);
        hold = 1'b1;
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_target = '0;
        cmd_if.cmd_step = 20'd0;
        repeat (10) tick();
        chk("hold_duty", duty_need, 525);
        chk("hold_busy", busy, 1);
        chk("hold_ready", cmd_if.cmd_ready, 0);
        hold = 1'b0;
        repeat (2) tick();
        cmd_if.cmd_valid = 1'b0;
        wait_done("hold_wait");
        chk("hold_final", duty_need, 600);

        send(20'hFFFFF, 200, 1);
        repeat (TD) tick();
        chk("clamp_800", duty_need, 800);
        wait_done("clamp_wait");
        chk("clamp_final", duty_need, DMAX);

        send(0, 100, 2);
        repeat (5) tick();
        chk("mid_900", duty_need, 900);
        rst = 1'b1;
        tick();
        chk("mid_rst_duty", duty_need, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_gap", duty_gap, 10);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            cmd_if.cmd_valid = ($urandom_range(0, 7) == 0);
            cmd_if.cmd_target = ($urandom_range(0, 9) == 0) ?
                20'hFFFFF : 20'($urandom_range(0, 1100));
            cmd_if.cmd_step = ($urandom_range(0, 4) == 0) ?
                20'd0 : 20'($urandom_range(20, 300));
            cmd_if.cmd_gap = 12'($urandom);
            hold = ($urandom_range(0, 3) == 0);
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        hold = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        tick();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
